// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the multiply/divide sequencer: operation codes,
// FSM state type, default latencies and the latency-class helper.
//
// Optional feature macro: MULDIV_MADD_EN
//   When defined, op code OP_MADD_GRP selects a multiply-accumulate group
//   whose flavour comes from a 2-bit sub-op (MADD_SUB_* constants).
//   When undefined, OP_MADD_GRP behaves like OP_NONE.
package muldiv_pkg;

  localparam logic [2:0] OP_NONE     = 3'd0;
  localparam logic [2:0] OP_MULT     = 3'd1;
  localparam logic [2:0] OP_MULTU    = 3'd2;
  localparam logic [2:0] OP_DIV      = 3'd3;
  localparam logic [2:0] OP_DIVU     = 3'd4;
  localparam logic [2:0] OP_MTHI     = 3'd5;
  localparam logic [2:0] OP_MTLO     = 3'd6;
  localparam logic [2:0] OP_MADD_GRP = 3'd7;

`ifdef MULDIV_MADD_EN
  // Bit 1 selects subtract, bit 0 selects the unsigned product.
  localparam logic [1:0] MADD_SUB_MADD  = 2'd0;
  localparam logic [1:0] MADD_SUB_MADDU = 2'd1;
  localparam logic [1:0] MADD_SUB_MSUB  = 2'd2;
  localparam logic [1:0] MADD_SUB_MSUBU = 2'd3;
`endif

  localparam int MULT_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT  = 10;
  localparam int CNT_W_DEFAULT       = 4;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  typedef enum logic [1:0] {
    LAT_NONE,
    LAT_MULT,
    LAT_DIV
  } lat_class_t;

  // Which latency an op needs; LAT_NONE means it completes (or does
  // nothing) in the cycle it is issued and never stalls.
  function automatic lat_class_t op_class(input logic [2:0] op);
    lat_class_t cls;
    cls = LAT_NONE;
    case (op)
      OP_MULT, OP_MULTU: cls = LAT_MULT;
      OP_DIV, OP_DIVU:   cls = LAT_DIV;
`ifdef MULDIV_MADD_EN
      OP_MADD_GRP:       cls = LAT_MULT;
`endif
      default:           cls = LAT_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/muldiv_arith.sv
// muldiv_arith
// Purely combinational 64-bit {hi,lo} result generator for every muldiv op.
// Ports:
//   op       operation code (muldiv_pkg OP_*)
//   madd_sub multiply-accumulate flavour (only with MULDIV_MADD_EN)
//   src_a    rs operand
//   src_b    rt operand
//   hi, lo   currently committed HI/LO (used by MTHI/MTLO/accumulate)
//   result   {new_hi, new_lo}
// Optional feature macro: MULDIV_MADD_EN
module muldiv_arith
  import muldiv_pkg::*;
(
  input  logic [2:0]  op,
`ifdef MULDIV_MADD_EN
  input  logic [1:0]  madd_sub,
`endif
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic        div_zero;

  assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  // Signed divide is done on magnitudes so that 0x80000000 / -1 falls out
  // naturally as 0x80000000 rem 0 instead of relying on signed overflow.
  assign a_neg = src_a[31];
  assign b_neg = src_b[31];
  assign a_mag = a_neg ? (32'd0 - src_a) : src_a;
  assign b_mag = b_neg ? (32'd0 - src_b) : src_b;
  assign div_zero = (src_b == 32'd0);

  // Divisors are forced to 1 on divide-by-zero so the dividers never see 0;
  // the quotient/remainder are replaced by the fixed result below anyway.
  assign q_mag = a_mag / (div_zero ? 32'd1 : b_mag);
  assign r_mag = a_mag % (div_zero ? 32'd1 : b_mag);
  assign q_s   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign r_s   = a_neg ? (32'd0 - r_mag) : r_mag;
  assign q_u   = src_a / (div_zero ? 32'd1 : src_b);
  assign r_u   = src_a % (div_zero ? 32'd1 : src_b);

  always_comb begin
    result = {hi, lo};
    case (op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV:   result = div_zero ? {src_a, 32'hFFFF_FFFF} : {r_s, q_s};
      OP_DIVU:  result = div_zero ? {src_a, 32'hFFFF_FFFF} : {r_u, q_u};
      OP_MTHI:  result = {src_a, lo};
      OP_MTLO:  result = {hi, src_a};
`ifdef MULDIV_MADD_EN
      OP_MADD_GRP: begin
        case (madd_sub)
          MADD_SUB_MADD:  result = {hi, lo} + prod_s;
          MADD_SUB_MADDU: result = {hi, lo} + prod_u;
          MADD_SUB_MSUB:  result = {hi, lo} - prod_s;
          MADD_SUB_MSUBU: result = {hi, lo} - prod_u;
          default:        result = {hi, lo};
        endcase
      end
`endif
      default:  result = {hi, lo};
    endcase
  end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq
// Multi-cycle multiply/divide sequencer with the HI/LO register pair,
// sitting beside the ALU in the E stage.
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset, clears all state
//   start     E-stage instruction is a muldiv op this cycle
//   op        operation code (muldiv_pkg OP_*)
//   madd_sub  accumulate flavour (only with MULDIV_MADD_EN)
//   src_a     rs operand
//   src_b     rt operand
//   busy      operation in flight (registered)
//   stall_req busy, or a long op being issued right now
//   hi, lo    committed HI/LO
// Optional feature macro: MULDIV_MADD_EN
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT,
  parameter int CNT_W       = CNT_W_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
`ifdef MULDIV_MADD_EN
  input  logic [1:0]  madd_sub,
`endif
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_t      state_q, state_n;
  logic [CNT_W-1:0] count_q, count_n;
  logic [63:0] pend_q, pend_n;
  logic [63:0] hilo_q, hilo_n;
  logic [63:0] result;
  lat_class_t  cls;

  // The result is computed from the operands and committed HI/LO present
  // at issue time, so accumulate ops see the pre-operation {hi,lo}.
  muldiv_arith u_arith (
    .op       (op),
`ifdef MULDIV_MADD_EN
    .madd_sub (madd_sub),
`endif
    .src_a    (src_a),
    .src_b    (src_b),
    .hi       (hilo_q[63:32]),
    .lo       (hilo_q[31:0]),
    .result   (result)
  );

  assign cls       = op_class(op);
  assign busy      = (state_q == ST_BUSY);
  assign stall_req = busy | (start & (cls != LAT_NONE));
  assign hi        = hilo_q[63:32];
  assign lo        = hilo_q[31:0];

  // Next-state logic: long ops park their result in the pending register
  // and count down; MTHI/MTLO write straight through; starts while busy
  // are dropped.
  always_comb begin
    state_n = state_q;
    count_n = count_q;
    pend_n  = pend_q;
    hilo_n  = hilo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (cls)
            LAT_MULT: begin
              pend_n  = result;
              count_n = CNT_W'(MULT_CYCLES);
              state_n = ST_BUSY;
            end
            LAT_DIV: begin
              pend_n  = result;
              count_n = CNT_W'(DIV_CYCLES);
              state_n = ST_BUSY;
            end
            default: begin
              if ((op == OP_MTHI) || (op == OP_MTLO)) begin
                hilo_n = result;
              end
            end
          endcase
        end
      end
      ST_BUSY: begin
        if (count_q == CNT_W'(1)) begin
          hilo_n  = pend_q;
          count_n = '0;
          state_n = ST_IDLE;
        end else begin
          count_n = count_q - CNT_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State registers; reset mid-operation abandons the pending result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      pend_q  <= '0;
      hilo_q  <= '0;
    end else begin
      state_q <= state_n;
      count_q <= count_n;
      pend_q  <= pend_n;
      hilo_q  <= hilo_n;
    end
  end

endmodule
